// File: rtl/uart_boot_loader_if.sv
// Memory write port between the boot loader and SoC memory.
//   mem_wr_valid : write request, held until accepted
//   mem_wr_ready : memory accepts the write when high together with valid
//   mem_wr_addr  : word-aligned byte address
//   mem_wr_data  : 32-bit write data
interface uart_boot_loader_if;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  modport master (output mem_wr_valid, mem_wr_addr, mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_valid, mem_wr_addr, mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image on rxd, writes it into
// SoC memory word by word, holds the SoC halted during the download and
// pulses the SoC reset after a download with a good checksum.
// Frame: A5 | ADDR[31:0] | COUNT[15:0] | COUNT x DATA[31:0] | CHK (little-endian)
//   clk, rst_n : system clock, asynchronous active-low reset
//   rxd        : raw UART line (8N1, idle high, asynchronous)
//   mem        : memory write port (master side)
//   halt       : SoC halt, high during a frame and after a failed frame
//   soc_rst_n  : active-low SoC reset pulse after a good frame
//   boot_done  : one-cycle pulse on a good frame
//   boot_error : sticky error flag, cleared by the next sync byte
//
// state         | meaning
// S_IDLE        | hunting for the 0xA5 sync byte
// S_ADDR        | collecting the 4 start-address bytes
// S_COUNT       | collecting the 2 word-count bytes
// S_DATA        | collecting data words and issuing writes
// S_CHK         | comparing checksum, then draining the last write
// S_RESET_PULSE | holding soc_rst_n low
module uart_boot_loader #(
  parameter int unsigned CLOCK_FREQ         = 50000000,
  parameter int unsigned BAUD_RATE          = 115200,
  parameter int unsigned TIMEOUT_CYCLES     = 5000000,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  uart_boot_loader_if.master mem,
  output logic               halt,
  output logic               soc_rst_n,
  output logic               boot_done,
  output logic               boot_error
);
  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RST_W  = $clog2(RESET_PULSE_CYCLES + 1);
  localparam logic [BAUD_W-1:0] BIT_LOAD  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RESET_PULSE_CYCLES - 1);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e         rx_state_q;
  logic              rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [BAUD_W-1:0] rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic              rx_strobe_q, rx_ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_strobe_q <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      rx_strobe_q <= 1'b0;
      rx_ferr_q   <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          // edge-triggered so a line left low by a bad stop bit does not retrigger
          if (rxd_prev_q && !rxd_sync_q) begin
            rx_cnt_q   <= HALF_LOAD;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            if (rxd_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_cnt_q   <= BIT_LOAD;
              rx_bit_q   <= '0;
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= BIT_LOAD;
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_strobe_q <= rxd_sync_q;
            rx_ferr_q   <= !rxd_sync_q;
            rx_state_q  <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CHK, S_RESET_PULSE} state_e;

  state_e           state_q;
  logic [1:0]       byte_cnt_q;
  logic [23:0]      shift_q;       // last three received bytes, newest on top
  logic [31:0]      addr_q;        // address of the next word to write
  logic [15:0]      words_left_q;
  logic [7:0]       chk_q;
  logic             chk_ok_q;
  logic [TMO_W-1:0] tmo_q;
  logic [RST_W-1:0] rst_cnt_q;
  logic             wr_valid_q;
  logic [31:0]      wr_addr_q, wr_data_q;
  logic             halt_q, soc_rst_n_q, boot_done_q, boot_error_q;

  logic [31:0] word_d;
  logic        in_frame, abort, wr_busy;

  always_comb begin
    word_d   = {rx_shift_q, shift_q};
    // once the checksum has matched, only the write drain remains
    in_frame = (state_q == S_ADDR) || (state_q == S_COUNT) || (state_q == S_DATA) ||
               ((state_q == S_CHK) && !chk_ok_q);
    abort    = in_frame && (rx_ferr_q || (!rx_strobe_q && (tmo_q == '0)));
    wr_busy  = wr_valid_q && !mem.mem_wr_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      chk_q        <= '0;
      chk_ok_q     <= 1'b0;
      tmo_q        <= '0;
      rst_cnt_q    <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      halt_q       <= 1'b0;
      soc_rst_n_q  <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_error_q <= 1'b0;
    end else begin
      boot_done_q <= 1'b0;
      // the handshake runs independently so a pending write completes even after an abort
      if (wr_valid_q && mem.mem_wr_ready) wr_valid_q <= 1'b0;
      if (rx_strobe_q)          tmo_q <= TMO_LOAD;
      else if (tmo_q != '0)     tmo_q <= tmo_q - 1'b1;

      if (abort) begin
        boot_error_q <= 1'b1;
        state_q      <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_strobe_q && (rx_shift_q == 8'hA5)) begin
              halt_q       <= 1'b1;
              boot_error_q <= 1'b0;
              chk_q        <= '0;
              chk_ok_q     <= 1'b0;
              byte_cnt_q   <= '0;
              state_q      <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (rx_strobe_q) begin
              chk_q      <= chk_q + rx_shift_q;
              shift_q    <= word_d[31:8];
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                addr_q  <= {word_d[31:2], 2'b00};
                state_q <= S_COUNT;
              end
            end
          end
          S_COUNT: begin
            if (rx_strobe_q) begin
              chk_q      <= chk_q + rx_shift_q;
              shift_q    <= word_d[31:8];
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd1) begin
                words_left_q <= word_d[31:16];
                byte_cnt_q   <= '0;
                state_q      <= (word_d[31:16] == 16'd0) ? S_CHK : S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_strobe_q) begin
              chk_q      <= chk_q + rx_shift_q;
              shift_q    <= word_d[31:8];
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                if (wr_busy) begin
                  boot_error_q <= 1'b1;
                  state_q      <= S_IDLE;
                end else begin
                  wr_valid_q   <= 1'b1;
                  wr_addr_q    <= addr_q;
                  wr_data_q    <= word_d;
                  addr_q       <= addr_q + 32'd4;
                  words_left_q <= words_left_q - 16'd1;
                  if (words_left_q == 16'd1) state_q <= S_CHK;
                end
              end
            end
          end
          S_CHK: begin
            if (!chk_ok_q) begin
              if (rx_strobe_q) begin
                if (rx_shift_q == chk_q) begin
                  chk_ok_q <= 1'b1;
                end else begin
                  boot_error_q <= 1'b1;
                  state_q      <= S_IDLE;
                end
              end
            end else if (!wr_valid_q) begin
              chk_ok_q    <= 1'b0;
              boot_done_q <= 1'b1;
              soc_rst_n_q <= 1'b0;
              rst_cnt_q   <= RST_LOAD;
              state_q     <= S_RESET_PULSE;
            end
          end
          S_RESET_PULSE: begin
            if (rst_cnt_q == '0) begin
              soc_rst_n_q <= 1'b1;
              halt_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              rst_cnt_q <= rst_cnt_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem.mem_wr_valid = wr_valid_q;
  assign mem.mem_wr_addr  = wr_addr_q;
  assign mem.mem_wr_data  = wr_data_q;
  assign halt             = halt_q;
  assign soc_rst_n        = soc_rst_n_q;
  assign boot_done        = boot_done_q;
  assign boot_error       = boot_error_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames driven on rxd, expected writes
// and checksums derived from the frame contents, one compare process on the
// negative clock edge.
module tb_uart_boot_loader;
  localparam int CPB   = 16;
  localparam int TMO   = 3000;
  localparam int PULSE = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rxd = 1'b1;
  logic halt, soc_rst_n, boot_done, boot_error;

  uart_boot_loader_if mem_if();

  uart_boot_loader #(
    .CLOCK_FREQ(1600), .BAUD_RATE(100), .TIMEOUT_CYCLES(TMO), .RESET_PULSE_CYCLES(PULSE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .mem(mem_if),
    .halt(halt), .soc_rst_n(soc_rst_n), .boot_done(boot_done), .boot_error(boot_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  logic [7:0] tx_q[$];
  int   done_cnt = 0;
  int   pulse_cnt = 0;
  int   low_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  wr_t  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = stop_ok;
    wait_cycles(CPB);
    rxd = 1'b1;
    if (!stop_ok) wait_cycles(CPB);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(tx_q[i], 1'b1);
  endtask

  // Builds the byte stream of a frame; expected writes are queued when the
  // frame is meant to deliver its words.
  task automatic build_frame(input logic [31:0] addr, input int nwords,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [7:0] chk_adj, input bit expect_writes,
                             output logic [7:0] chk);
    logic [31:0] words[2];
    logic [15:0] cnt;
    wr_t e;
    words[0] = w0;
    words[1] = w1;
    cnt = 16'(nwords);
    tx_q.delete();
    tx_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) tx_q.push_back(addr[8*i +: 8]);
    tx_q.push_back(cnt[7:0]);
    tx_q.push_back(cnt[15:8]);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < 4; b++) tx_q.push_back(words[w][8*b +: 8]);
      if (expect_writes) begin
        e.addr = (addr & 32'hFFFF_FFFC) + 32'(4 * w);
        e.data = words[w];
        exp_q.push_back(e);
      end
    end
    chk = 8'h00;
    for (int i = 1; i < tx_q.size(); i++) chk = chk + tx_q[i];
    tx_q.push_back(chk + chk_adj);
  endtask

  // compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt    = 0;
      prev_valid = 1'b0;
    end else begin
      if (mem_if.mem_wr_valid && prev_valid && !prev_ready) begin
        check("wr_addr_stable", mem_if.mem_wr_addr, prev_addr);
        check("wr_data_stable", mem_if.mem_wr_data, prev_data);
      end
      if (mem_if.mem_wr_valid && mem_if.mem_wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h required=none",
                   mem_if.mem_wr_addr, mem_if.mem_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mem_if.mem_wr_addr, mon_e.addr);
          check("wr_data", mem_if.mem_wr_data, mon_e.data);
        end
      end
      if (boot_done) done_cnt++;
      if (!soc_rst_n) begin
        low_cnt++;
        check("halt_during_pulse", 32'(halt), 32'd1);
      end else if (low_cnt != 0) begin
        check("pulse_len", low_cnt, PULSE);
        check("halt_at_release", 32'(halt), 32'd0);
        pulse_cnt++;
        low_cnt = 0;
      end
      prev_valid = mem_if.mem_wr_valid;
      prev_ready = mem_if.mem_wr_ready;
      prev_addr  = mem_if.mem_wr_addr;
      prev_data  = mem_if.mem_wr_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] chk;
    logic [7:0] junk[3];
    bit fired;
    junk[0] = 8'h00;
    junk[1] = 8'hFF;
    junk[2] = 8'h13;
    mem_if.mem_wr_ready = 1'b1;
    #1 rst_n = 1'b0;
    wait_cycles(3);
    check("rst_valid", 32'(mem_if.mem_wr_valid), 32'd0);
    check("rst_addr", mem_if.mem_wr_addr, 32'd0);
    check("rst_data", mem_if.mem_wr_data, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_soc_rst_n", 32'(soc_rst_n), 32'd1);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_boot_error", 32'(boot_error), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // junk before sync, then a good frame with ready tied high
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i], 1'b1);
      wait_cycles(4);
      check("halt_junk", 32'(halt), 32'd0);
    end
    build_frame(32'h0000_0100, 2, 32'h4433_2211, 32'h8877_6655, 8'h00, 1'b1, chk);
    check("model_chk", 32'(chk), 32'h67);
    check("model_wr0_addr", exp_q[0].addr, 32'h0000_0100);
    check("model_wr1_addr", exp_q[1].addr, 32'h0000_0104);
    send_range(0, 0);
    wait_cycles(2);
    check("halt_after_sync", 32'(halt), 32'd1);
    send_range(1, tx_q.size() - 1);
    wait_cycles(100);
    check("good_done_cnt", done_cnt, 1);
    check("good_pulse_cnt", pulse_cnt, 1);
    check("good_writes_left", exp_q.size(), 0);
    check("good_error", 32'(boot_error), 32'd0);
    check("good_halt", 32'(halt), 32'd0);

    // first word stalled 1000 cycles, unaligned start address
    build_frame(32'h1000_0002, 2, 32'hCAFE_F00D, 32'h0123_4567, 8'h00, 1'b1, chk);
    check("model_align", exp_q[0].addr, 32'h1000_0000);
    mem_if.mem_wr_ready = 1'b0;
    send_range(0, 10);
    for (int i = 0; i < 1000; i++) begin
      check("stall_valid", 32'(mem_if.mem_wr_valid), 32'd1);
      wait_cycles(1);
    end
    check("stall_no_accept", exp_q.size(), 2);
    mem_if.mem_wr_ready = 1'b1;
    send_range(11, tx_q.size() - 1);
    wait_cycles(100);
    check("stall_done_cnt", done_cnt, 2);
    check("stall_pulse_cnt", pulse_cnt, 2);
    check("stall_writes_left", exp_q.size(), 0);
    check("stall_error", 32'(boot_error), 32'd0);

    // checksum off by one
    build_frame(32'h0000_0100, 2, 32'h4433_2211, 32'h8877_6655, 8'h01, 1'b1, chk);
    check("model_bad_chk", 32'(tx_q[tx_q.size() - 1]), 32'h68);
    send_range(0, tx_q.size() - 1);
    wait_cycles(100);
    check("badchk_done_cnt", done_cnt, 2);
    check("badchk_pulse_cnt", pulse_cnt, 2);
    check("badchk_writes_left", exp_q.size(), 0);
    check("badchk_soc_rst_n", 32'(soc_rst_n), 32'd1);
    check("badchk_error", 32'(boot_error), 32'd1);
    check("badchk_halt", 32'(halt), 32'd1);

    // framing error on the first data byte, then a good frame
    build_frame(32'h0000_0200, 1, 32'hDEAD_BEEF, 32'h0, 8'h00, 1'b0, chk);
    send_range(0, 6);
    send_byte(tx_q[7], 1'b0);
    wait_cycles(10);
    check("ferr_error", 32'(boot_error), 32'd1);
    check("ferr_halt", 32'(halt), 32'd1);
    build_frame(32'h0000_0300, 1, 32'h0BAD_F00D, 32'h0, 8'h00, 1'b1, chk);
    send_range(0, 0);
    wait_cycles(2);
    check("ferr_error_cleared", 32'(boot_error), 32'd0);
    send_range(1, tx_q.size() - 1);
    wait_cycles(100);
    check("recover_done_cnt", done_cnt, 3);
    check("recover_pulse_cnt", pulse_cnt, 3);
    check("recover_writes_left", exp_q.size(), 0);
    check("recover_error", 32'(boot_error), 32'd0);
    check("recover_halt", 32'(halt), 32'd0);

    // stall after COUNT: inter-byte timeout
    build_frame(32'h0000_0400, 2, 32'h1111_1111, 32'h2222_2222, 8'h00, 1'b0, chk);
    send_range(0, 6);
    wait_cycles(TMO - 60);
    check("tmo_early", 32'(boot_error), 32'd0);
    fired = 1'b0;
    for (int i = 0; i < 200 && !fired; i++) begin
      wait_cycles(1);
      fired = boot_error;
    end
    check("tmo_fire", 32'(boot_error), 32'd1);
    check("tmo_halt", 32'(halt), 32'd1);
    check("tmo_done_cnt", done_cnt, 3);

    // asynchronous reset in the middle of a frame with a pending write
    build_frame(32'h0000_0500, 1, 32'h55AA_55AA, 32'h0, 8'h00, 1'b0, chk);
    mem_if.mem_wr_ready = 1'b0;
    send_range(0, 10);
    wait_cycles(2);
    check("prerst_valid", 32'(mem_if.mem_wr_valid), 32'd1);
    check("prerst_halt", 32'(halt), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(mem_if.mem_wr_valid), 32'd0);
    check("arst_addr", mem_if.mem_wr_addr, 32'd0);
    check("arst_data", mem_if.mem_wr_data, 32'd0);
    check("arst_halt", 32'(halt), 32'd0);
    check("arst_soc_rst_n", 32'(soc_rst_n), 32'd1);
    check("arst_boot_done", 32'(boot_done), 32'd0);
    check("arst_boot_error", 32'(boot_error), 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    mem_if.mem_wr_ready = 1'b1;
    wait_cycles(20);
    check("postrst_valid", 32'(mem_if.mem_wr_valid), 32'd0);
    check("postrst_halt", 32'(halt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
